control_seq_4bit: RTL
=====================

Name: control_seq_4bit

Overview:
- Instruction-sequencing control stage directly upstream of dat_proc_unit_4bit.
- Fetches 16-bit instructions from an external combinational-read instruction ROM, decodes them, and drives the datapath control word.
- Latches datapath status flags (V,C,N,Z) and uses them for conditional branches.
- Two cycles per instruction (FETCH, EXEC); supports start/halt.

Parameters:
PC_WIDTH, 8, program counter and instruction address width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
start  input  1  leaves IDLE/HALT; PC restarts at 0
instr_addr  output  PC_WIDTH  current PC to instruction ROM
instr_data  input  16  ROM data for instr_addr, same cycle
V, C, N, Z  input  1 each  datapath status flags, combinational in EXEC
load_enable  output  1  register-file write strobe
D_select, A_select, B_select  output  2 each  destination, source A, source B registers
G_select  output  4  function-unit op
H_select  output  2  shifter op
MB_select  output  1  1 = constant_input onto B
MF_select  output  1  1 = shifter result, 0 = function unit
MD_select  output  1  1 = data_input to register file
constant_input  output  4  immediate
halted  output  1  high in HALT
status  output  4  latched {V,C,N,Z}

Behaviour:
- Instruction fields:
  - op = [15:12]
  - dr = [11:10]
  - sa = [9:8]
  - sb = [7:6]
  - imm = [3:0]
  - [5:4] ignored
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, any state, including mid-instruction):
  - state = IDLE, PC = 0, IR = 0, status = 0.
  - All control outputs 0; halted = 0.
- IDLE: start=1 -> FETCH, PC = 0.
- FETCH:
  - IR <= instr_data at the clock edge; -> EXEC.
  - load_enable = 0.
- EXEC:
  - Control word is a combinational decode of IR.
  - D_select = dr, A_select = sa, B_select = sb, constant_input = imm.
  - Unlisted control fields are 0.
  - load_enable = 1 for ops 1–E only.
  - PC <= PC+1 (modulo 2^PC_WIDTH) unless a branch is taken; -> FETCH.
- Opcodes:
  - 0 NOP: load_enable = 0.
  - 1 MOV: G = 0000.
  - 2 INC: G = 0001.
  - 3 ADD: G = 0010.
  - 4 SUB: G = 0101.
  - 5 DEC: G = 0110.
  - 6 AND: G = 1000.
  - 7 OR: G = 1010.
  - 8 XOR: G = 1100.
  - 9 NOT: G = 1110.
  - A LDI: MB = 1, MF = 1, H = 00 (dr <= imm).
  - B ADI: MB = 1, G = 0010.
  - C SHR: MF = 1, H = 01.
  - D SHL: MF = 1, H = 10.
  - E IN: MD = 1.
  - F CTRL, sub-op = sb, load_enable = 0:
    - 00 BRZ: taken if status.Z = 1.
    - 01 BRN: taken if status.N = 1.
    - 10 JMP: always taken.
    - 11 HLT: -> HALT, PC unchanged.
- Branch target = PC + 1 + sign_extend(imm), modulo 2^PC_WIDTH. Offset range is -8..+7; wrap-around is legal.
- Status latch:
  - Ops 2–9 and B: status <= {V,C,N,Z} at the end of EXEC.
  - All other ops hold status.
  - Branches test the latched status, never the live flags.
- HALT:
  - halted = 1; control outputs 0.
  - start=1 -> FETCH with PC = 0; status is kept.
- start is ignored in FETCH/EXEC.
- instr_addr = PC in all states.

Test Plan:
- Reset/start:
  - Hold reset_n=0 -> all outputs 0, instr_addr = 0.
  - Release reset, pulse start -> FETCH at PC = 0, EXEC next cycle, PC = 1 after EXEC.
- Decode sweep:
  - ROM 0x3E40 (ADD r3<=r2+r1) -> EXEC shows load_enable=1, D=3, A=2, B=1, G=0010, MB=MF=MD=0.
  - ROM 0xA005 -> D=0, MB=1, MF=1, H=00, constant_input=5.
- Status/BRZ:
  - SUB with flags Z=1 driven -> status = 0001.
  - Following BRZ imm=4'b1110 at PC=5 -> next instr_addr = 4.
  - Same with Z=0 -> instr_addr = 6.
- Flag isolation:
  - MOV while bench drives Z=1 after status Z=0 -> status unchanged; subsequent BRZ not taken.
- Wrap:
  - JMP imm=7 at PC=0xFA -> PC = 0x02.
  - Straight-line NOP at PC=0xFF -> PC = 0x00.
- Halt/async reset:
  - HLT -> halted=1, load_enable stays 0 for 10 cycles.
  - start -> PC = 0.
  - Assert reset_n mid-EXEC (between edges) -> outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/control_seq_4bit.sv
// Purpose : instruction sequencer for dat_proc_unit_4bit; fetches, decodes, branches on latched flags.
// Latency : two cycles per instruction (FETCH then EXEC); control word is valid only during EXEC.
// Backpres: none; runs freely once started, parks in IDLE/HALT until start.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 leave IDLE/HALT and restart at PC 0 (ignored in FETCH/EXEC)
//   instr_addr/instr_data combinational-read instruction ROM interface
//   V, C, N, Z            live datapath flags, sampled at the end of EXEC
//   load_enable .. constant_input  datapath control word (all zero outside EXEC)
//   halted                high while in HALT
//   status                latched {V,C,N,Z}
module control_seq_4bit #(
   parameter int PC_WIDTH = 8   // must be greater than 4 (branch offset is sign-extended from 4 bits)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   output logic [PC_WIDTH-1:0] instr_addr,
   input  logic [15:0]         instr_data,
   input  logic                V,
   input  logic                C,
   input  logic                N,
   input  logic                Z,
   output logic                load_enable,
   output logic [1:0]          D_select,
   output logic [1:0]          A_select,
   output logic [1:0]          B_select,
   output logic [3:0]          G_select,
   output logic [1:0]          H_select,
   output logic                MB_select,
   output logic                MF_select,
   output logic                MD_select,
   output logic [3:0]          constant_input,
   output logic                halted,
   output logic [3:0]          status
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [PC_WIDTH-1:0] pc, pc_nxt;
   logic [15:0]         ir, ir_nxt;
   logic [3:0]          status_nxt;

   // Instruction fields
   logic [3:0] op;
   logic [1:0] dr, sa, sb;
   logic [3:0] imm;
   logic       unused_ir_bits;

   assign op  = ir[15:12];
   assign dr  = ir[11:10];
   assign sa  = ir[9:8];
   assign sb  = ir[7:6];
   assign imm = ir[3:0];
   assign unused_ir_bits = ^ir[5:4];

   logic [PC_WIDTH-1:0] pc_inc, br_target;

   assign pc_inc    = pc + PC_WIDTH'(1);
   // Offset is relative to the following instruction; wrap-around is intended.
   assign br_target = pc_inc + {{(PC_WIDTH-4){imm[3]}}, imm};

   assign instr_addr = pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         pc     <= '0;
         ir     <= '0;
         status <= '0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         ir     <= ir_nxt;
         status <= status_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      ir_nxt         = ir;
      status_nxt     = status;
      load_enable    = 1'b0;
      D_select       = 2'b00;
      A_select       = 2'b00;
      B_select       = 2'b00;
      G_select       = 4'b0000;
      H_select       = 2'b00;
      MB_select      = 1'b0;
      MF_select      = 1'b0;
      MD_select      = 1'b0;
      constant_input = 4'b0000;
      halted         = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = '0;
            end
         end

         S_FETCH: begin
            ir_nxt    = instr_data;
            state_nxt = S_EXEC;
         end

         S_EXEC: begin
            D_select       = dr;
            A_select       = sa;
            B_select       = sb;
            constant_input = imm;
            // NOP (0) and CTRL (F) never write the register file
            load_enable    = (op != 4'h0) && (op != 4'hF);
            state_nxt      = S_FETCH;
            pc_nxt         = pc_inc;

            case (op)
               4'h2: G_select = 4'b0001;
               4'h3: G_select = 4'b0010;
               4'h4: G_select = 4'b0101;
               4'h5: G_select = 4'b0110;
               4'h6: G_select = 4'b1000;
               4'h7: G_select = 4'b1010;
               4'h8: G_select = 4'b1100;
               4'h9: G_select = 4'b1110;
               4'hA: begin
                  MB_select = 1'b1;
                  MF_select = 1'b1;
               end
               4'hB: begin
                  MB_select = 1'b1;
                  G_select  = 4'b0010;
               end
               4'hC: begin
                  MF_select = 1'b1;
                  H_select  = 2'b01;
               end
               4'hD: begin
                  MF_select = 1'b1;
                  H_select  = 2'b10;
               end
               4'hE: MD_select = 1'b1;
               4'hF: begin
                  // Branch conditions use the latched status, not the live flags
                  case (sb)
                     2'b00: if (status[0]) pc_nxt = br_target;
                     2'b01: if (status[1]) pc_nxt = br_target;
                     2'b10: pc_nxt = br_target;
                     default: begin
                        state_nxt = S_HALT;
                        pc_nxt    = pc;
                     end
                  endcase
               end
               default: ;
            endcase

            // Only ALU-style ops (2..9 and ADI) update the status latch
            if (((op >= 4'h2) && (op <= 4'h9)) || (op == 4'hB)) begin
               status_nxt = {V, C, N, Z};
            end
         end

         S_HALT: begin
            halted = 1'b1;
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = '0;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
